wb_forward_pipe: RTL and testbench

- Writeback/forwarding stage between the even and odd execution pipes and the 128x128 dual-issue register file.
- Carries each issued result through a DEPTH-stage shift register per pipe, then drives the register file write ports (rt addr/data, wr_en) at the last stage.
- Resolves the six operand reads (ra/rb/rc, even/odd): returns the forwarded value when a younger in-flight result targets that register, and flags a hazard when that result is not yet ready.

---
 rtl/wb_forward_pipe.sv | 175 +++++++++++++++++
 tb/tb_wb_forward_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_forward_pipe.sv
// Writeback/forwarding stage: DEPTH-deep result pipes for the even and odd units,
// register-file writeback at the last stage, and six-way operand forwarding with hazard detection.
// Optional build macro HAZARD_CNT_EN adds a saturating 32-bit hazard-cycle counter output.
module wb_forward_pipe #(
    parameter int WIDTH   = 128,
    parameter int LOGSIZE = 7,
    parameter int DEPTH   = 7,
    parameter int LATW    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ev_valid_in,
    input  logic                od_valid_in,
    input  logic [LOGSIZE-1:0]  ev_rt_addr_in,
    input  logic [LOGSIZE-1:0]  od_rt_addr_in,
    input  logic [WIDTH-1:0]    ev_data_in,
    input  logic [WIDTH-1:0]    od_data_in,
    input  logic [LATW-1:0]     ev_lat_in,
    input  logic [LATW-1:0]     od_lat_in,
    input  logic                flush_in,
    input  logic [LOGSIZE-1:0]  rd_addr_in [0:5],
    input  logic [WIDTH-1:0]    rf_data_in [0:5],
    output logic [WIDTH-1:0]    opnd_out [0:5],
    output logic [5:0]          hazard_out,
    output logic [LOGSIZE-1:0]  rt_even_addr_out,
    output logic [LOGSIZE-1:0]  rt_odd_addr_out,
    output logic [WIDTH-1:0]    rt_even_data_out,
    output logic [WIDTH-1:0]    rt_odd_data_out,
    output logic                wr_en_even_out,
    output logic                wr_en_odd_out
`ifdef HAZARD_CNT_EN
    ,
    output logic [31:0]         hazard_cnt_out
`endif
);

    localparam int NRD = 6;

    // Clamp an issued latency into the legal 1..DEPTH range.
    function automatic logic [LATW-1:0] clamp_lat(input logic [LATW-1:0] lat);
        logic [LATW-1:0] res;
        if (lat == {LATW{1'b0}}) begin
            res = {{(LATW-1){1'b0}}, 1'b1};
        end else if (32'(lat) > 32'(DEPTH)) begin
            res = LATW'(DEPTH);
        end else begin
            res = lat;
        end
        return res;
    endfunction

    logic [DEPTH:1]      ev_vld_r;
    logic [DEPTH:1]      od_vld_r;
    logic [LOGSIZE-1:0]  ev_addr_r [1:DEPTH];
    logic [LOGSIZE-1:0]  od_addr_r [1:DEPTH];
    logic [WIDTH-1:0]    ev_data_r [1:DEPTH];
    logic [WIDTH-1:0]    od_data_r [1:DEPTH];
    logic [LATW-1:0]     ev_lat_r  [1:DEPTH];
    logic [LATW-1:0]     od_lat_r  [1:DEPTH];

    logic [DEPTH:1]      ev_rdy_s;
    logic [DEPTH:1]      od_rdy_s;
    logic                wb_coll_s;
    logic [NRD-1:0]      hit_s;
    logic [NRD-1:0]      hit_rdy_s;
    logic [WIDTH-1:0]    hit_data_s [0:NRD-1];
    logic                ev_m_s;
    logic                od_m_s;

    // Result pipes: capture into stage 1, shift every cycle; a flush empties stages 1..3 on the way in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_vld_r <= '0;
            od_vld_r <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                ev_addr_r[k] <= '0;
                od_addr_r[k] <= '0;
                ev_data_r[k] <= '0;
                od_data_r[k] <= '0;
                ev_lat_r[k]  <= '0;
                od_lat_r[k]  <= '0;
            end
        end else begin
            ev_vld_r[1]  <= ev_valid_in & ~flush_in;
            od_vld_r[1]  <= od_valid_in & ~flush_in;
            ev_addr_r[1] <= ev_rt_addr_in;
            od_addr_r[1] <= od_rt_addr_in;
            ev_data_r[1] <= ev_data_in;
            od_data_r[1] <= od_data_in;
            ev_lat_r[1]  <= clamp_lat(ev_lat_in);
            od_lat_r[1]  <= clamp_lat(od_lat_in);
            for (int k = 2; k <= DEPTH; k++) begin
                ev_vld_r[k]  <= (flush_in && (k <= 3)) ? 1'b0 : ev_vld_r[k-1];
                od_vld_r[k]  <= (flush_in && (k <= 3)) ? 1'b0 : od_vld_r[k-1];
                ev_addr_r[k] <= ev_addr_r[k-1];
                od_addr_r[k] <= od_addr_r[k-1];
                ev_data_r[k] <= ev_data_r[k-1];
                od_data_r[k] <= od_data_r[k-1];
                ev_lat_r[k]  <= ev_lat_r[k-1];
                od_lat_r[k]  <= od_lat_r[k-1];
            end
        end
    end

    // An entry is forwardable once its stage index has reached its latency.
    always_comb begin
        ev_rdy_s = '0;
        od_rdy_s = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            ev_rdy_s[k] = (k >= int'(ev_lat_r[k]));
            od_rdy_s[k] = (k >= int'(od_lat_r[k]));
        end
    end

    // Writeback from the last stage; odd wins a same-register collision.
    always_comb begin
        wb_coll_s        = ev_vld_r[DEPTH] && od_vld_r[DEPTH] &&
                           (ev_addr_r[DEPTH] == od_addr_r[DEPTH]);
        wr_en_even_out   = ev_vld_r[DEPTH] && !wb_coll_s;
        wr_en_odd_out    = od_vld_r[DEPTH];
        rt_even_addr_out = ev_vld_r[DEPTH] ? ev_addr_r[DEPTH] : '0;
        rt_even_data_out = ev_vld_r[DEPTH] ? ev_data_r[DEPTH] : '0;
        rt_odd_addr_out  = od_vld_r[DEPTH] ? od_addr_r[DEPTH] : '0;
        rt_odd_data_out  = od_vld_r[DEPTH] ? od_data_r[DEPTH] : '0;
    end

    // Operand resolution: scan oldest to youngest so the youngest match (odd before even) lands last.
    always_comb begin
        hit_s      = '0;
        hit_rdy_s  = '0;
        hazard_out = '0;
        ev_m_s     = 1'b0;
        od_m_s     = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            hit_data_s[i] = '0;
            opnd_out[i]   = rf_data_in[i];
        end
        for (int i = 0; i < NRD; i++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                ev_m_s        = ev_vld_r[k] && (ev_addr_r[k] == rd_addr_in[i]);
                hit_s[i]      = hit_s[i] | ev_m_s;
                hit_rdy_s[i]  = ev_m_s ? ev_rdy_s[k]  : hit_rdy_s[i];
                hit_data_s[i] = ev_m_s ? ev_data_r[k] : hit_data_s[i];
                od_m_s        = od_vld_r[k] && (od_addr_r[k] == rd_addr_in[i]);
                hit_s[i]      = hit_s[i] | od_m_s;
                hit_rdy_s[i]  = od_m_s ? od_rdy_s[k]  : hit_rdy_s[i];
                hit_data_s[i] = od_m_s ? od_data_r[k] : hit_data_s[i];
            end
            if (hit_s[i] && hit_rdy_s[i]) begin
                opnd_out[i]   = hit_data_s[i];
                hazard_out[i] = 1'b0;
            end else if (hit_s[i]) begin
                opnd_out[i]   = rf_data_in[i];
                hazard_out[i] = 1'b1;
            end else begin
                opnd_out[i]   = rf_data_in[i];
                hazard_out[i] = 1'b0;
            end
        end
    end

`ifdef HAZARD_CNT_EN
    // Saturating count of cycles with at least one operand hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard_cnt_out <= 32'd0;
        end else if ((|hazard_out) && (hazard_cnt_out != 32'hFFFF_FFFF)) begin
            hazard_cnt_out <= hazard_cnt_out + 32'd1;
        end else begin
            hazard_cnt_out <= hazard_cnt_out;
        end
    end
`endif

endmodule

// File: tb/tb_wb_forward_pipe.sv
// Self-checking bench for wb_forward_pipe: queue-based reference model plus directed literal checks.
module tb_wb_forward_pipe;

    localparam int W = 128;
    localparam int L = 7;
    localparam int D = 7;

    logic          clk;
    logic          rst_n;
    logic          ev_valid_in, od_valid_in;
    logic [L-1:0]  ev_rt_addr_in, od_rt_addr_in;
    logic [W-1:0]  ev_data_in, od_data_in;
    logic [2:0]    ev_lat_in, od_lat_in;
    logic          flush_in;
    logic [L-1:0]  rd_addr_in [0:5];
    logic [W-1:0]  rf_data_in [0:5];
    logic [W-1:0]  opnd_out [0:5];
    logic [5:0]    hazard_out;
    logic [L-1:0]  rt_even_addr_out, rt_odd_addr_out;
    logic [W-1:0]  rt_even_data_out, rt_odd_data_out;
    logic          wr_en_even_out, wr_en_odd_out;
`ifdef HAZARD_CNT_EN
    logic [31:0]   hazard_cnt_out;
`endif

    wb_forward_pipe #(.WIDTH(W), .LOGSIZE(L), .DEPTH(D), .LATW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .ev_valid_in(ev_valid_in), .od_valid_in(od_valid_in),
        .ev_rt_addr_in(ev_rt_addr_in), .od_rt_addr_in(od_rt_addr_in),
        .ev_data_in(ev_data_in), .od_data_in(od_data_in),
        .ev_lat_in(ev_lat_in), .od_lat_in(od_lat_in),
        .flush_in(flush_in),
        .rd_addr_in(rd_addr_in), .rf_data_in(rf_data_in),
        .opnd_out(opnd_out), .hazard_out(hazard_out),
        .rt_even_addr_out(rt_even_addr_out), .rt_odd_addr_out(rt_odd_addr_out),
        .rt_even_data_out(rt_even_data_out), .rt_odd_data_out(rt_odd_data_out),
        .wr_en_even_out(wr_en_even_out), .wr_en_odd_out(wr_en_odd_out)
`ifdef HAZARD_CNT_EN
        , .hazard_cnt_out(hazard_cnt_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: every in-flight result with the cycle it was issued in.
    typedef struct {
        int           ic;
        bit           odd;
        logic [L-1:0] addr;
        logic [W-1:0] data;
        int           lat;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    bit   any_hz = 1'b0;
    longint exp_hcnt = 0;

    function automatic int eff_lat(input int l);
        return (l < 1) ? 1 : ((l > D) ? D : l);
    endfunction

    // Model state update at each rising edge.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            exp_hcnt = 0;
        end else begin
            if (any_hz && exp_hcnt < 64'hFFFF_FFFF) exp_hcnt++;
            if (flush_in) begin
                for (int j = q.size() - 1; j >= 0; j--) begin
                    if ((cyc - q[j].ic) == 1 || (cyc - q[j].ic) == 2) q.delete(j);
                end
            end else begin
                if (ev_valid_in) q.push_back('{cyc, 1'b0, ev_rt_addr_in, ev_data_in, int'(ev_lat_in)});
                if (od_valid_in) q.push_back('{cyc, 1'b1, od_rt_addr_in, od_data_in, int'(od_lat_in)});
            end
            for (int j = q.size() - 1; j >= 0; j--) begin
                if ((cyc - q[j].ic) >= D) q.delete(j);
            end
        end
        cyc++;
    end

    initial forever begin
        @(negedge rst_n);
        q.delete();
        exp_hcnt = 0;
        any_hz = 1'b0;
    end

    // Compare process: every falling edge, all outputs against the model.
    initial forever begin
        bit           we_e, we_o, found, hz, bodd, anyh;
        logic [L-1:0] a_e, a_o;
        logic [W-1:0] d_e, d_o, bd;
        int           s, bs, bl;
        @(negedge clk);
        we_e = 1'b0; we_o = 1'b0; a_e = '0; a_o = '0; d_e = '0; d_o = '0;
        foreach (q[j]) begin
            if ((cyc - q[j].ic) == D) begin
                if (q[j].odd) begin we_o = 1'b1; a_o = q[j].addr; d_o = q[j].data; end
                else begin we_e = 1'b1; a_e = q[j].addr; d_e = q[j].data; end
            end
        end
        if (we_e && we_o && a_e == a_o) we_e = 1'b0;
        chk("wr_en_even", W'(wr_en_even_out), W'(we_e));
        chk("wr_en_odd", W'(wr_en_odd_out), W'(we_o));
        if (we_e) begin
            chk("rt_even_addr", W'(rt_even_addr_out), W'(a_e));
            chk("rt_even_data", rt_even_data_out, d_e);
        end
        if (we_o) begin
            chk("rt_odd_addr", W'(rt_odd_addr_out), W'(a_o));
            chk("rt_odd_data", rt_odd_data_out, d_o);
        end
        anyh = 1'b0;
        for (int i = 0; i < 6; i++) begin
            found = 1'b0; bs = D + 1; bodd = 1'b0; bd = '0; bl = 1;
            foreach (q[j]) begin
                s = cyc - q[j].ic;
                if (s >= 1 && s <= D && q[j].addr == rd_addr_in[i] &&
                    (s < bs || (s == bs && q[j].odd && !bodd))) begin
                    found = 1'b1; bs = s; bodd = q[j].odd; bd = q[j].data; bl = q[j].lat;
                end
            end
            hz = found && (bs < eff_lat(bl));
            anyh = anyh | hz;
            chk($sformatf("hazard%0d", i), W'(hazard_out[i]), W'(hz));
            if (!hz) chk($sformatf("opnd%0d", i), opnd_out[i], found ? bd : rf_data_in[i]);
        end
        any_hz = anyh;
`ifdef HAZARD_CNT_EN
        chk("hazard_cnt", W'(hazard_cnt_out), W'(exp_hcnt));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ev_valid_in = 1'b0; od_valid_in = 1'b0; flush_in = 1'b0;
    endtask

    function automatic logic [W-1:0] pat(input logic [7:0] b);
        return {16{b}};
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        ev_rt_addr_in = '0; od_rt_addr_in = '0; ev_data_in = '0; od_data_in = '0;
        ev_lat_in = 3'd1; od_lat_in = 3'd1;
        for (int i = 0; i < 6; i++) begin
            rd_addr_in[i] = L'(100 + i);
            rf_data_in[i] = pat(8'(8'hC0 + i));
        end
        repeat (3) tick();
        chk("rst_wr_en_even", W'(wr_en_even_out), W'(1'b0));
        chk("rst_rt_even_addr", W'(rt_even_addr_out), W'(0));
        chk("rst_rt_odd_data", rt_odd_data_out, '0);
        chk("rst_opnd0", opnd_out[0], pat(8'hC0));
        rst_n = 1'b1;
        tick();

        // Single even result r5, latency 2.
        rd_addr_in[0] = 7'd5;
        for (int c = 0; c <= 8; c++) begin
            idle();
            if (c == 0) begin
                ev_valid_in = 1'b1; ev_rt_addr_in = 7'd5; ev_data_in = pat(8'hA5); ev_lat_in = 3'd2;
            end
            #3;
            if (c == 1) chk("t1_hz_c1", W'(hazard_out[0]), W'(1'b1));
            if (c == 2) chk("t1_opnd_c2", opnd_out[0], pat(8'hA5));
            if (c == 6) chk("t1_noweb_c6", W'(wr_en_even_out), W'(1'b0));
            if (c == 7) begin
                chk("t1_we_c7", W'(wr_en_even_out), W'(1'b1));
                chk("t1_addr_c7", W'(rt_even_addr_out), W'(7'd5));
                chk("t1_data_c7", rt_even_data_out, pat(8'hA5));
            end
            if (c == 8) chk("t1_opnd_c8", opnd_out[0], pat(8'hC0));
            tick();
        end
        rd_addr_in[0] = 7'd100;

        // Even r9=1 then odd r9=2: younger odd forwards, writes one cycle apart.
        rd_addr_in[1] = 7'd9;
        for (int c = 0; c <= 9; c++) begin
            idle();
            if (c == 0) begin ev_valid_in = 1'b1; ev_rt_addr_in = 7'd9; ev_data_in = W'(1); ev_lat_in = 3'd1; end
            if (c == 1) begin od_valid_in = 1'b1; od_rt_addr_in = 7'd9; od_data_in = W'(2); od_lat_in = 3'd1; end
            #3;
            if (c == 1) chk("t2_opnd_c1", opnd_out[1], W'(1));
            if (c == 2) chk("t2_opnd_c2", opnd_out[1], W'(2));
            if (c == 7) begin
                chk("t2_we_e_c7", W'(wr_en_even_out), W'(1'b1));
                chk("t2_we_o_c7", W'(wr_en_odd_out), W'(1'b0));
            end
            if (c == 8) begin
                chk("t2_we_o_c8", W'(wr_en_odd_out), W'(1'b1));
                chk("t2_data_o_c8", rt_odd_data_out, W'(2));
            end
            tick();
        end

        // Same-cycle even/odd to r3: odd forwards and wins writeback.
        rd_addr_in[2] = 7'd3;
        for (int c = 0; c <= 8; c++) begin
            idle();
            if (c == 0) begin
                ev_valid_in = 1'b1; ev_rt_addr_in = 7'd3; ev_data_in = pat(8'h33); ev_lat_in = 3'd2;
                od_valid_in = 1'b1; od_rt_addr_in = 7'd3; od_data_in = pat(8'h44); od_lat_in = 3'd2;
            end
            #3;
            if (c == 1) chk("t3_hz_c1", W'(hazard_out[2]), W'(1'b1));
            if (c == 2) chk("t3_opnd_c2", opnd_out[2], pat(8'h44));
            if (c == 7) begin
                chk("t3_we_e_c7", W'(wr_en_even_out), W'(1'b0));
                chk("t3_we_o_c7", W'(wr_en_odd_out), W'(1'b1));
                chk("t3_data_c7", rt_odd_data_out, pat(8'h44));
            end
            tick();
        end

        // Flush: stage-3 entry survives, stage 1/2 entries and the new input are dropped.
        for (int c = -2; c <= 9; c++) begin
            idle();
            if (c == -2) begin od_valid_in = 1'b1; od_rt_addr_in = 7'd13; od_data_in = pat(8'h0D); od_lat_in = 3'd1; end
            if (c == -1) begin ev_valid_in = 1'b1; ev_rt_addr_in = 7'd14; ev_data_in = pat(8'h0E); ev_lat_in = 3'd1; end
            if (c == 0)  begin ev_valid_in = 1'b1; ev_rt_addr_in = 7'd11; ev_data_in = pat(8'h0B); ev_lat_in = 3'd1; end
            if (c == 1)  begin
                ev_valid_in = 1'b1; ev_rt_addr_in = 7'd12; ev_data_in = pat(8'h0C); ev_lat_in = 3'd1;
                flush_in = 1'b1; rd_addr_in[3] = 7'd11;
            end
            #3;
            if (c == 1) chk("t4_opnd_c1", opnd_out[3], pat(8'h0B));
            if (c == 2) chk("t4_opnd_c2", opnd_out[3], pat(8'hC3));
            if (c == 5) chk("t4_we_o_c5", W'(wr_en_odd_out), W'(1'b1));
            if (c == 6) chk("t4_we_e_c6", W'(wr_en_even_out), W'(1'b0));
            if (c == 7 || c == 8) chk("t4_we_e_c78", W'(wr_en_even_out), W'(1'b0));
            tick();
        end

        // Latency clamps, and a younger unready match masking an older ready one.
        rd_addr_in[3] = 7'd20; rd_addr_in[4] = 7'd21; rd_addr_in[5] = 7'd30;
        for (int c = 0; c <= 9; c++) begin
            idle();
            if (c == 0) begin
                ev_valid_in = 1'b1; ev_rt_addr_in = 7'd20; ev_data_in = pat(8'h20); ev_lat_in = 3'd0;
                od_valid_in = 1'b1; od_rt_addr_in = 7'd21; od_data_in = pat(8'h21); od_lat_in = 3'd7;
            end
            if (c == 1) begin ev_valid_in = 1'b1; ev_rt_addr_in = 7'd30; ev_data_in = pat(8'h30); ev_lat_in = 3'd1; end
            if (c == 2) begin od_valid_in = 1'b1; od_rt_addr_in = 7'd30; od_data_in = pat(8'h31); od_lat_in = 3'd5; end
            #3;
            if (c == 1) begin
                chk("t5_lat0_opnd", opnd_out[3], pat(8'h20));
                chk("t5_lat7_hz_c1", W'(hazard_out[4]), W'(1'b1));
            end
            if (c == 2) chk("t5_old_opnd_c2", opnd_out[5], pat(8'h30));
            if (c == 3) chk("t5_young_hz_c3", W'(hazard_out[5]), W'(1'b1));
            if (c == 6) chk("t5_lat7_hz_c6", W'(hazard_out[4]), W'(1'b1));
            if (c == 7) begin
                chk("t5_lat7_opnd_c7", opnd_out[4], pat(8'h21));
                chk("t5_addr_o_c7", W'(rt_odd_addr_out), W'(7'd21));
            end
            tick();
        end

        // Reset in the middle of traffic drops everything.
        rd_addr_in[0] = 7'd40;
        for (int c = 0; c <= 10; c++) begin
            idle();
            if (c <= 2) begin
                ev_valid_in = 1'b1; ev_rt_addr_in = L'(40 + c); ev_data_in = pat(8'(8'h40 + c)); ev_lat_in = 3'd3;
            end
            if (c == 4) rst_n = 1'b0;
            if (c == 6) rst_n = 1'b1;
            #3;
            if (c == 1) chk("t6_hz_c1", W'(hazard_out[0]), W'(1'b1));
            if (c == 4) begin
                chk("t6_hz_rst", W'(hazard_out), W'(6'd0));
                chk("t6_opnd_rst", opnd_out[0], pat(8'hC0));
                chk("t6_addr_rst", W'(rt_even_addr_out), W'(0));
`ifdef HAZARD_CNT_EN
                chk("t6_cnt_rst", W'(hazard_cnt_out), W'(0));
`endif
            end
            if (c >= 7) chk("t6_no_we", W'(wr_en_even_out), W'(1'b0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
